// File: rtl/user_io_fifo_bridge.sv
// user_io_fifo_bridge: GPIO word capture into a FIFO, replayed as narrower beats under edge-acknowledge handshake.
// Ports: wb_clk_i clock; wb_rst_i async active-high reset;
//        io_in  {out_ack, in_strobe, word[IN_W-1:0]};
//        io_out {overflow, out_valid, beat[OUT_W-1:0]};
//        io_oeb pad output enables, active-low.
module user_io_fifo_bridge #(
  parameter int IN_W = 16,
  parameter int OUT_W = 8,
  parameter int DEPTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [IN_W+1:0]   io_in,
  output logic [OUT_W+1:0]  io_out,
  output logic [OUT_W+1:0]  io_oeb
);
  localparam int BEATS = IN_W / OUT_W;
  localparam int AW = $clog2(DEPTH);
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  logic [IN_W+1:0] sync [SYNC_STAGES];
  logic [IN_W+1:0] sin;
  logic stb_d, ack_d, overflow;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [BW-1:0] beat;
  logic [IN_W-1:0] mem [DEPTH];
  logic [IN_W-1:0] head;
  logic push, ack_ev, empty, full, last, adv, pop, wr_ok;
  assign sin = sync[SYNC_STAGES-1];
  assign push = sin[IN_W] & ~stb_d;
  assign ack_ev = sin[IN_W+1] & ~ack_d;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign last = beat == BW'(BEATS-1);
  assign adv = ack_ev & ~empty;
  assign pop = adv & last;
  // A push into a full FIFO still succeeds when the head is popped in the same cycle.
  assign wr_ok = push & (~full | pop);
  assign head = mem[rd_ptr];
  assign io_out = {overflow, ~empty, empty ? OUT_W'(0) : head[beat*OUT_W +: OUT_W]};
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync[s] <= '0;
      stb_d <= 1'b0;
      ack_d <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      beat <= '0;
      overflow <= 1'b0;
      io_oeb <= '1;
    end else begin
      sync[0] <= io_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync[s] <= sync[s-1];
      stb_d <= sin[IN_W];
      ack_d <= sin[IN_W+1];
      io_oeb <= '0;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (adv) beat <= last ? '0 : beat + 1'b1;
      if (push & ~wr_ok) overflow <= 1'b1;
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge wb_clk_i)
    if (wr_ok) mem[wr_ptr] <= sin[IN_W-1:0];
endmodule

// File: tb/tb_user_io_fifo_bridge.sv
// tb_user_io_fifo_bridge: directed self-checking bench for user_io_fifo_bridge at default parameters.
module tb_user_io_fifo_bridge;
  logic clk = 1'b0;
  logic rst;
  logic [17:0] io_in;
  logic [9:0] io_out, io_oeb;
  int n_cmp = 0;
  int n_bad = 0;

  user_io_fifo_bridge dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .io_in(io_in),
    .io_out(io_out),
    .io_oeb(io_oeb)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [15:0] w);
    io_in[15:0] = w;
    @(negedge clk);
    io_in[16] = 1'b1;
    repeat (4) @(negedge clk);
    io_in[16] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ack();
    io_in[17] = 1'b1;
    repeat (4) @(negedge clk);
    io_in[17] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_cmp++;
    if (io_oeb !== 10'h3ff) begin
      n_bad++;
      $display("FAIL reset_oeb_held: got %h want 3ff", io_oeb);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (io_oeb !== 10'h000 || io_out !== 10'h000) begin
      n_bad++;
      $display("FAIL reset_release: oeb %h out %h want 000/000", io_oeb, io_out);
    end
    @(negedge clk);
    push(16'h00C3);
    n_cmp++;
    if (io_out !== 10'h1C3) begin
      n_bad++;
      $display("FAIL reset_prefill: got %h want 1c3", io_out);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (io_out !== 10'h000 || io_oeb !== 10'h3ff) begin
      n_bad++;
      $display("FAIL reset_async: out %h oeb %h want 000/3ff", io_out, io_oeb);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (io_oeb !== 10'h000 || io_out[8] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_after: oeb %h valid %b want 000/0", io_oeb, io_out[8]);
    end
    @(negedge clk);
  endtask

  task automatic test_single_word();
    io_in[15:0] = 16'hA55A;
    @(negedge clk);
    io_in[16] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (io_out[8] !== 1'b0) begin
      n_bad++;
      $display("FAIL push_latency_early: valid %b want 0", io_out[8]);
    end
    @(negedge clk);
    n_cmp++;
    if (io_out !== 10'h15A) begin
      n_bad++;
      $display("FAIL push_latency: got %h want 15a", io_out);
    end
    @(negedge clk);
    io_in[16] = 1'b0;
    repeat (3) @(negedge clk);
    io_in[17] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (io_out !== 10'h15A) begin
      n_bad++;
      $display("FAIL ack_latency_early: got %h want 15a", io_out);
    end
    @(negedge clk);
    n_cmp++;
    if (io_out !== 10'h1A5) begin
      n_bad++;
      $display("FAIL ack_beat1: got %h want 1a5", io_out);
    end
    @(negedge clk);
    io_in[17] = 1'b0;
    repeat (3) @(negedge clk);
    ack();
    n_cmp++;
    if (io_out !== 10'h000) begin
      n_bad++;
      $display("FAIL single_pop: got %h want 000", io_out);
    end
    ack();
    n_cmp++;
    if (io_out !== 10'h000 || dut.beat !== 1'b0) begin
      n_bad++;
      $display("FAIL ack_empty_ignored: out %h beat %b want 000/0", io_out, dut.beat);
    end
  endtask

  task automatic test_overflow();
    pulse_reset();
    for (int i = 1; i <= 9; i++) push(16'(i));
    n_cmp++;
    if (dut.count !== 4'd8 || io_out[9] !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_set: count %0d ovf %b want 8/1", dut.count, io_out[9]);
    end
    for (int i = 1; i <= 8; i++) begin
      n_cmp++;
      if (io_out !== {2'b11, 8'(i)}) begin
        n_bad++;
        $display("FAIL overflow_drain_lo: word %0d got %h want %h", i, io_out, {2'b11, 8'(i)});
      end
      ack();
      n_cmp++;
      if (io_out !== 10'h300) begin
        n_bad++;
        $display("FAIL overflow_drain_hi: word %0d got %h want 300", i, io_out);
      end
      ack();
    end
    n_cmp++;
    if (io_out !== 10'h200) begin
      n_bad++;
      $display("FAIL overflow_lost: got %h want 200", io_out);
    end
  endtask

  task automatic test_simul_full();
    logic [15:0] exp [8];
    pulse_reset();
    for (int i = 1; i <= 8; i++) push(16'h0101 * 16'(i));
    ack();
    io_in[15:0] = 16'h00FF;
    @(negedge clk);
    io_in[16] = 1'b1;
    io_in[17] = 1'b1;
    repeat (4) @(negedge clk);
    io_in[16] = 1'b0;
    io_in[17] = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (dut.count !== 4'd8 || io_out[9] !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_full: count %0d ovf %b want 8/0", dut.count, io_out[9]);
    end
    for (int i = 0; i < 7; i++) exp[i] = 16'h0101 * 16'(i + 2);
    exp[7] = 16'h00FF;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (io_out !== {2'b01, exp[i][7:0]}) begin
        n_bad++;
        $display("FAIL simul_drain_lo: idx %0d got %h want %h", i, io_out, {2'b01, exp[i][7:0]});
      end
      ack();
      n_cmp++;
      if (io_out !== {2'b01, exp[i][15:8]}) begin
        n_bad++;
        $display("FAIL simul_drain_hi: idx %0d got %h want %h", i, io_out, {2'b01, exp[i][15:8]});
      end
      ack();
    end
  endtask

  task automatic test_wrap();
    logic [15:0] w;
    pulse_reset();
    for (int i = 0; i < 22; i++) begin
      if (i < 20) push(16'h1F00 + 16'(i * 3));
      if (i >= 2) begin
        w = 16'h1F00 + 16'((i - 2) * 3);
        n_cmp++;
        if (io_out !== {2'b01, w[7:0]}) begin
          n_bad++;
          $display("FAIL wrap_lo: word %0d got %h want %h", i - 2, io_out, {2'b01, w[7:0]});
        end
        ack();
        n_cmp++;
        if (io_out !== {2'b01, w[15:8]}) begin
          n_bad++;
          $display("FAIL wrap_hi: word %0d got %h want %h", i - 2, io_out, {2'b01, w[15:8]});
        end
        ack();
      end
    end
    n_cmp++;
    if (io_out !== 10'h000) begin
      n_bad++;
      $display("FAIL wrap_end: got %h want 000", io_out);
    end
  endtask

  task automatic test_mid_reset();
    push(16'hBEEF);
    ack();
    n_cmp++;
    if (io_out !== 10'h1BE) begin
      n_bad++;
      $display("FAIL midrst_pre: got %h want 1be", io_out);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (io_out[8] !== 1'b0 || dut.beat !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_async: valid %b beat %b want 0/0", io_out[8], dut.beat);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push(16'h1234);
    n_cmp++;
    if (io_out !== 10'h134) begin
      n_bad++;
      $display("FAIL midrst_lo: got %h want 134", io_out);
    end
    ack();
    n_cmp++;
    if (io_out !== 10'h112) begin
      n_bad++;
      $display("FAIL midrst_hi: got %h want 112", io_out);
    end
    ack();
    n_cmp++;
    if (io_out !== 10'h000) begin
      n_bad++;
      $display("FAIL midrst_end: got %h want 000", io_out);
    end
  endtask

  initial begin
    rst = 1'b1;
    io_in = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_word();
    test_overflow();
    test_simul_full();
    test_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
